price_band_monitor: RTL and testbench

Parametrised, programmable successor to the single-channel price threshold detector. It classifies a qualified price stream against runtime-programmable upper/lower bands with hysteresis, separate entry and exit debounce, and direct HIGH<->LOW crash transitions. It reports the state level, a one-cycle transition event and a saturating dwell count. It sits between the price feed decoder and the order/alert logic; all outputs are registered.

---
 rtl/price_band_if.sv | 26 ++
 rtl/price_band_monitor.sv | 146 ++++++++++++++
 tb/tb_price_band_monitor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/price_band_if.sv
// Price sample and classification bus between the feed decoder side and the band monitor.
interface price_band_if #(
  parameter int unsigned PRICE_W = 8,
  parameter int unsigned DWELL_W = 16
);
  logic               price_valid;
  logic [PRICE_W-1:0] price;
  logic [PRICE_W-1:0] upper_band;
  logic [PRICE_W-1:0] lower_band;
  logic [PRICE_W-1:0] hyst;
  logic [1:0]         out;
  logic               evt_valid;
  logic [1:0]         evt_code;
  logic [DWELL_W-1:0] dwell;
  logic               cfg_err;

  modport master (
    output price_valid, price, upper_band, lower_band, hyst,
    input  out, evt_valid, evt_code, dwell, cfg_err
  );

  modport slave (
    input  price_valid, price, upper_band, lower_band, hyst,
    output out, evt_valid, evt_code, dwell, cfg_err
  );
endinterface

// File: rtl/price_band_monitor.sv
// Classifies a qualified price stream into BAND/HIGH/LOW with debounced entry,
// hysteresis-relaxed debounced exit and direct HIGH<->LOW crash transitions.
module price_band_monitor #(
  parameter int unsigned PRICE_W         = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned EXIT_CYCLES     = 2,
  parameter int unsigned DWELL_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  price_band_if.slave bus
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned EXT_W = $clog2(EXIT_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_TGT = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [EXT_W-1:0] EXT_TGT = EXT_W'(EXIT_CYCLES);

  typedef enum logic [1:0] {
    ST_BAND = 2'b01,
    ST_HIGH = 2'b11,
    ST_LOW  = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [DEB_W-1:0]   up_cnt, up_nxt;
  logic [DEB_W-1:0]   dn_cnt, dn_nxt;
  logic [DEB_W-1:0]   crash_cnt, crash_nxt;
  logic [EXT_W-1:0]   exit_cnt, exit_nxt;
  logic [DWELL_W-1:0] dwell_q, dwell_nxt;
  logic               evt_q, evt_nxt;
  logic [1:0]         code_q, code_nxt;
  logic               cfg_q, cfg_nxt;

  logic               above, below, cfg_bad;
  logic [PRICE_W:0]   hi_diff, lo_sum;
  logic [PRICE_W-1:0] hi_exit_thr, lo_exit_thr;

  function automatic logic [DEB_W-1:0] inc_deb(input logic [DEB_W-1:0] c);
    return (c == DEB_TGT) ? c : c + DEB_W'(1);
  endfunction

  function automatic logic [EXT_W-1:0] inc_ext(input logic [EXT_W-1:0] c);
    return (c == EXT_TGT) ? c : c + EXT_W'(1);
  endfunction

  // Band comparisons and saturating hysteresis exit thresholds
  always_comb begin
    above       = (bus.price >= bus.upper_band);
    below       = (bus.price <= bus.lower_band);
    cfg_bad     = (bus.lower_band >= bus.upper_band);
    hi_diff     = {1'b0, bus.upper_band} - {1'b0, bus.hyst};
    lo_sum      = {1'b0, bus.lower_band} + {1'b0, bus.hyst};
    hi_exit_thr = hi_diff[PRICE_W] ? '0 : hi_diff[PRICE_W-1:0];
    lo_exit_thr = lo_sum[PRICE_W]  ? '1 : lo_sum[PRICE_W-1:0];
  end

  // Next-state, counter and event logic; everything holds on invalid cycles
  always_comb begin
    state_nxt = state;
    up_nxt    = up_cnt;
    dn_nxt    = dn_cnt;
    exit_nxt  = exit_cnt;
    crash_nxt = crash_cnt;
    dwell_nxt = dwell_q;
    evt_nxt   = 1'b0;
    code_nxt  = code_q;
    cfg_nxt   = cfg_q;

    if (bus.price_valid) begin
      cfg_nxt = cfg_bad;
      if (cfg_bad) begin
        state_nxt = ST_BAND;
        up_nxt    = '0;
        dn_nxt    = '0;
        exit_nxt  = '0;
        crash_nxt = '0;
      end else begin
        case (state)
          ST_BAND: begin
            up_nxt = above ? inc_deb(up_cnt) : '0;
            dn_nxt = below ? inc_deb(dn_cnt) : '0;
            if (up_nxt == DEB_TGT)      state_nxt = ST_HIGH;
            else if (dn_nxt == DEB_TGT) state_nxt = ST_LOW;
          end
          ST_HIGH: begin
            exit_nxt  = (bus.price < hi_exit_thr) ? inc_ext(exit_cnt) : '0;
            crash_nxt = below ? inc_deb(crash_cnt) : '0;
            if (crash_nxt == DEB_TGT)     state_nxt = ST_LOW;
            else if (exit_nxt == EXT_TGT) state_nxt = ST_BAND;
          end
          ST_LOW: begin
            exit_nxt  = (bus.price > lo_exit_thr) ? inc_ext(exit_cnt) : '0;
            crash_nxt = above ? inc_deb(crash_cnt) : '0;
            if (crash_nxt == DEB_TGT)     state_nxt = ST_HIGH;
            else if (exit_nxt == EXT_TGT) state_nxt = ST_BAND;
          end
          default: state_nxt = ST_BAND;
        endcase
      end

      if (state_nxt != state) begin
        up_nxt    = '0;
        dn_nxt    = '0;
        exit_nxt  = '0;
        crash_nxt = '0;
        dwell_nxt = '0;
        evt_nxt   = 1'b1;
        code_nxt  = state_nxt;
      end else begin
        dwell_nxt = (&dwell_q) ? dwell_q : dwell_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_BAND;
      up_cnt    <= '0;
      dn_cnt    <= '0;
      exit_cnt  <= '0;
      crash_cnt <= '0;
      dwell_q   <= '0;
      evt_q     <= 1'b0;
      code_q    <= 2'b01;
      cfg_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      up_cnt    <= up_nxt;
      dn_cnt    <= dn_nxt;
      exit_cnt  <= exit_nxt;
      crash_cnt <= crash_nxt;
      dwell_q   <= dwell_nxt;
      evt_q     <= evt_nxt;
      code_q    <= code_nxt;
      cfg_q     <= cfg_nxt;
    end
  end

  assign bus.out       = state;
  assign bus.evt_valid = evt_q;
  assign bus.evt_code  = code_q;
  assign bus.dwell     = dwell_q;
  assign bus.cfg_err   = cfg_q;

endmodule

// File: tb/tb_price_band_monitor.sv
// Directed and randomized checks of price_band_monitor against a per-sample
// behavioural model of the band classification rules.
module tb_price_band_monitor;

  localparam int unsigned PRICE_W = 8;
  localparam int unsigned DEB     = 3;
  localparam int unsigned EXT     = 2;
  localparam int unsigned DWELL_W = 5;
  localparam int PMAX   = 255;
  localparam int DWMAX  = 31;
  localparam int S_BAND = 1;
  localparam int S_HIGH = 3;
  localparam int S_LOW  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  price_band_if #(.PRICE_W(PRICE_W), .DWELL_W(DWELL_W)) bus ();

  price_band_monitor #(
    .PRICE_W(PRICE_W), .DEBOUNCE_CYCLES(DEB), .EXIT_CYCLES(EXT), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus currently applied
  int t_up = 105, t_lo = 95, t_hy = 2;
  int cur_v, cur_p, cur_rst;

  // reference model state
  int m_state, m_up, m_dn, m_ex, m_cr, m_dwell, m_evt, m_code, m_cfg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int c, input int lim);
    return (c >= lim) ? lim : c + 1;
  endfunction

  task automatic model_edge();
    int nst, hthr, lthr;
    if (cur_rst != 0) begin
      m_state = S_BAND; m_up = 0; m_dn = 0; m_ex = 0; m_cr = 0;
      m_dwell = 0; m_evt = 0; m_code = S_BAND; m_cfg = 0;
      return;
    end
    m_evt = 0;
    if (cur_v == 0) return;
    nst   = m_state;
    m_cfg = (t_lo >= t_up) ? 1 : 0;
    hthr  = (t_up - t_hy < 0) ? 0 : t_up - t_hy;
    lthr  = (t_lo + t_hy > PMAX) ? PMAX : t_lo + t_hy;
    if (m_cfg != 0) begin
      nst = S_BAND; m_up = 0; m_dn = 0; m_ex = 0; m_cr = 0;
    end else if (m_state == S_BAND) begin
      if (cur_p >= t_up)      begin m_up = sat_inc(m_up, DEB); m_dn = 0; end
      else if (cur_p <= t_lo) begin m_dn = sat_inc(m_dn, DEB); m_up = 0; end
      else                    begin m_up = 0; m_dn = 0; end
      if (m_up == DEB)      nst = S_HIGH;
      else if (m_dn == DEB) nst = S_LOW;
    end else if (m_state == S_HIGH) begin
      m_ex = (cur_p < hthr) ? sat_inc(m_ex, EXT) : 0;
      m_cr = (cur_p <= t_lo) ? sat_inc(m_cr, DEB) : 0;
      if (m_cr == DEB)      nst = S_LOW;
      else if (m_ex == EXT) nst = S_BAND;
    end else begin
      m_ex = (cur_p > lthr) ? sat_inc(m_ex, EXT) : 0;
      m_cr = (cur_p >= t_up) ? sat_inc(m_cr, DEB) : 0;
      if (m_cr == DEB)      nst = S_HIGH;
      else if (m_ex == EXT) nst = S_BAND;
    end
    if (nst != m_state) begin
      m_up = 0; m_dn = 0; m_ex = 0; m_cr = 0;
      m_dwell = 0; m_evt = 1; m_code = nst; m_state = nst;
    end else begin
      m_dwell = sat_inc(m_dwell, DWMAX);
    end
  endtask

  task automatic step(input int rst, input int v, input int p);
    @(negedge clk);
    cur_rst = rst; cur_v = v; cur_p = p;
    reset           = (rst != 0);
    bus.price_valid = (v != 0);
    bus.price       = PRICE_W'(p);
    bus.upper_band  = PRICE_W'(t_up);
    bus.lower_band  = PRICE_W'(t_lo);
    bus.hyst        = PRICE_W'(t_hy);
    @(posedge clk);
    model_edge();
    #1;
    check("out",       32'(bus.out),       32'(m_state));
    check("evt_valid", 32'(bus.evt_valid), 32'(m_evt));
    check("evt_code",  32'(bus.evt_code),  32'(m_code));
    check("dwell",     32'(bus.dwell),     32'(m_dwell));
    check("cfg_err",   32'(bus.cfg_err),   32'(m_cfg));
  endtask

  initial begin
    int lo_r, hi_r;
    reset = 1'b1;
    bus.price_valid = 1'b0;
    bus.price = '0; bus.upper_band = '0; bus.lower_band = '0; bus.hyst = '0;

    // reset state
    step(1, 0, 0);
    check("rst_out",   32'(bus.out),       32'd1);
    check("rst_dwell", 32'(bus.dwell),     32'd0);
    check("rst_code",  32'(bus.evt_code),  32'd1);

    // rise with a gap
    step(0, 1, 110); step(0, 0, 0); step(0, 1, 106);
    check("rise_pre", 32'(bus.out), 32'd1);
    step(0, 1, 105);
    check("rise_out", 32'(bus.out), 32'd3);
    check("rise_evt", 32'(bus.evt_valid), 32'd1);
    step(0, 1, 106);
    check("rise_dwell", 32'(bus.dwell), 32'd1);

    // hysteresis hold then exit
    step(0, 1, 104); step(0, 1, 103); step(0, 1, 104); step(0, 1, 103);
    check("hyst_hold", 32'(bus.out), 32'd3);
    step(0, 1, 102);
    check("hyst_one", 32'(bus.out), 32'd3);
    step(0, 1, 101);
    check("hyst_exit", 32'(bus.out), 32'd1);

    // interrupted debounce
    step(0, 1, 110); step(0, 1, 100); step(0, 1, 110); step(0, 1, 110);
    check("intr_hold", 32'(bus.out), 32'd1);
    step(0, 1, 110);
    check("intr_high", 32'(bus.out), 32'd3);

    // crash HIGH->LOW with the exit threshold pushed down to lower_band
    t_hy = 10;
    step(0, 1, 95); step(0, 1, 95);
    check("crash_hold", 32'(bus.out), 32'd3);
    step(0, 1, 95);
    check("crash_out",  32'(bus.out), 32'd2);
    check("crash_code", 32'(bus.evt_code), 32'd2);

    // config error from LOW, then recovery
    t_lo = 110;
    step(0, 1, 100);
    check("cfg_set", 32'(bus.cfg_err), 32'd1);
    check("cfg_out", 32'(bus.out), 32'd1);
    check("cfg_evt", 32'(bus.evt_valid), 32'd1);
    t_lo = 95; t_hy = 2;
    step(0, 0, 100);
    check("cfg_hold", 32'(bus.cfg_err), 32'd1);
    step(0, 1, 100);
    check("cfg_clr", 32'(bus.cfg_err), 32'd0);

    // reset mid-debounce
    step(0, 1, 110); step(0, 1, 110);
    step(1, 1, 110);
    check("rmid_out", 32'(bus.out), 32'd1);
    check("rmid_evt", 32'(bus.evt_valid), 32'd0);
    step(0, 1, 110); step(0, 1, 110);
    check("rmid_hold", 32'(bus.out), 32'd1);
    step(0, 1, 110);
    check("rmid_high", 32'(bus.out), 32'd3);

    // randomized traffic including threshold changes, config errors and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        t_up = int'($urandom_range(90, 130));
        if ($urandom_range(0, 4) == 0) t_lo = int'($urandom_range(t_up, t_up + 20));
        else                           t_lo = int'($urandom_range(60, t_up - 1));
        if ($urandom_range(0, 7) == 0) t_hy = int'($urandom_range(120, 255));
        else                           t_hy = int'($urandom_range(0, 20));
      end
      lo_r = (t_lo - 15 < 0) ? 0 : t_lo - 15;
      hi_r = (t_up + 15 > PMAX) ? PMAX : t_up + 15;
      step(($urandom_range(0, 99) == 0) ? 1 : 0,
           ($urandom_range(0, 4) != 0) ? 1 : 0,
           int'($urandom_range(hi_r, lo_r)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
